// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the parametrised register file:
//   default geometry, the $rstatus index, a constant-foldable clog2 and
//   the default register address type.
// ----------------------------------------------------------------------------
package regfile_pkg;

  // Constant-foldable ceil(log2(value)); usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_DEPTH      = 32;
  localparam int DEFAULT_AW         = clog2(DEFAULT_DEPTH);
  localparam int DEFAULT_STATUS_IDX = DEFAULT_DEPTH - 1;

  typedef logic [DEFAULT_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//   Busy-bit tracker for destination registers owned by in-flight multicycle
//   operations (mult/div). A register becomes busy when its op is issued and
//   is released when its result is written back.
//
//   Ports
//     clock        in   rising-edge clock
//     ctrl_reset   in   synchronous active-high reset (clears every busy bit)
//     set          in   mark set_reg busy
//     set_reg      in   register being claimed
//     clr          in   primary write-back, releases clr_reg
//     clr_reg      in   register being written back
//     clr_status   in   $rstatus side write, releases STATUS_IDX
//     busy         out  registered busy vector (bit 0 is always 0)
//     count        out  number of busy registers
//     full         out  every writable register is busy
//
//   Priority: a set of register r beats a same-cycle release of r, because
//   the set represents a newer owner of that destination.
// ----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int STATUS_IDX = DEPTH - 1,
  parameter int AW         = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             set,
  input  logic [AW-1:0]    set_reg,
  input  logic             clr,
  input  logic [AW-1:0]    clr_reg,
  input  logic             clr_status,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]      count,
  output logic             full
);

  typedef logic [AW:0] cnt_t;

  localparam logic [AW-1:0] STATUS_ADDR = AW'(STATUS_IDX);

  logic             set_live;
  logic             set_new;
  logic             clr_new;
  logic             clr_status_new;
  logic [DEPTH-1:0] busy_d;

  // The count moves by the bits that actually change, so it equals the
  // popcount of busy without needing a full adder tree.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    set_live = set && (set_reg != '0);
    set_new  = set_live && !busy[set_reg];
    clr_new  = clr && (clr_reg != '0) && busy[clr_reg]
               && !(set_live && (set_reg == clr_reg));
    // A primary write-back to $rstatus already accounts for its release.
    clr_status_new = clr_status && busy[STATUS_IDX]
                     && !(set_live && (set_reg == STATUS_ADDR))
                     && !(clr && (clr_reg == STATUS_ADDR));

    busy_d = busy;
    if (clr)        busy_d[clr_reg]    = 1'b0;
    if (clr_status) busy_d[STATUS_IDX] = 1'b0;
    if (set_live)   busy_d[set_reg]    = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= busy_d;
      count <= count + cnt_t'(set_new) - cnt_t'(clr_new) - cnt_t'(clr_status_new);
    end
  end

  assign full = (count == cnt_t'(DEPTH - 1));

endmodule

// File: rtl/regfile_param.sv
// ----------------------------------------------------------------------------
// regfile_param
//   Parametrised processor register file: NREAD combinational read ports,
//   one primary write port, one $rstatus side-write port, register 0 hardwired
//   to zero, and a built-in scoreboard of registers owned by in-flight
//   multicycle ops.
//
//   Ports
//     clock             in   rising-edge clock
//     ctrl_reset        in   synchronous active-high reset
//     ctrl_writeEnable  in   primary write enable
//     ctrl_writeReg     in   primary write address
//     data_writeReg     in   primary write data
//     rs_write          in   $rstatus side write (independent of ctrl_writeEnable)
//     rs_writeData      in   $rstatus side-write data
//     ctrl_readReg      in   read addresses, port k = [k*AW +: AW]
//     data_readReg      out  read data, port k = [k*WIDTH +: WIDTH]
//     sb_set            in   mark sb_setReg busy
//     sb_setReg         in   destination of the issued multicycle op
//     sb_busy           out  bit k = register addressed by read port k is busy
//     sb_count          out  number of busy registers
//     sb_full           out  all writable registers busy
//
//   Build option
//     REGFILE_BYPASS_EN  defined: reads (data and busy) see same-cycle writes.
//                        undefined: reads return the pre-edge state.
// ----------------------------------------------------------------------------
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int NREAD      = 2,
  parameter int STATUS_IDX = DEPTH - 1,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic                   ctrl_writeEnable,
  input  logic [AW-1:0]          ctrl_writeReg,
  input  logic [WIDTH-1:0]       data_writeReg,
  input  logic                   rs_write,
  input  logic [WIDTH-1:0]       rs_writeData,
  input  logic [NREAD*AW-1:0]    ctrl_readReg,
  output logic [NREAD*WIDTH-1:0] data_readReg,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_setReg,
  output logic [NREAD-1:0]       sb_busy,
  output logic [AW:0]            sb_count,
  output logic                   sb_full
);

  localparam logic [AW-1:0] STATUS_ADDR = AW'(STATUS_IDX);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             primary_we;

  // The side write owns $rstatus outright, so the primary port is masked
  // there rather than relying on assignment order.
  assign primary_we = ctrl_writeEnable && (ctrl_writeReg != '0)
                      && !(rs_write && (ctrl_writeReg == STATUS_ADDR));

  // NOTE: the array is built from flops, so reset clears every entry; a
  // RAM-macro implementation could not be reset this way.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (primary_we) regs[ctrl_writeReg] <= data_writeReg;
      if (rs_write)   regs[STATUS_IDX]    <= rs_writeData;
    end
  end

  regfile_scoreboard #(
    .DEPTH      (DEPTH),
    .STATUS_IDX (STATUS_IDX),
    .AW         (AW)
  ) u_scoreboard (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .set        (sb_set),
    .set_reg    (sb_setReg),
    .clr        (ctrl_writeEnable),
    .clr_reg    (ctrl_writeReg),
    .clr_status (rs_write),
    .busy       (busy),
    .count      (sb_count),
    .full       (sb_full)
  );

  always_comb begin
    data_readReg = '0;
    sb_busy      = '0;
    for (int k = 0; k < NREAD; k++) begin
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] rd;
      logic             bz;
      addr = ctrl_readReg[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      if (rs_write && (addr == STATUS_ADDR)) begin
        rd = rs_writeData;
      end else if (ctrl_writeEnable && (addr == ctrl_writeReg)) begin
        rd = data_writeReg;
      end else begin
        rd = regs[addr];
      end
      // A releasing write shows the register free unless a same-cycle
      // issue claims it again.
      if ((ctrl_writeEnable && (addr == ctrl_writeReg))
          || (rs_write && (addr == STATUS_ADDR))) begin
        bz = sb_set && (sb_setReg == addr);
      end else begin
        bz = busy[addr];
      end
`else
      rd = regs[addr];
      bz = busy[addr];
`endif
      if (addr == '0) begin
        rd = '0;
        bz = 1'b0;
      end
      data_readReg[k*WIDTH +: WIDTH] = rd;
      sb_busy[k]                     = bz;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// ----------------------------------------------------------------------------
// tb_regfile_param
//   Self-checking bench for regfile_param (WIDTH=32, DEPTH=32, NREAD=3).
//   Stimulus pushes the expected read-side view into a queue; a monitor on
//   the falling edge pops and compares. The reference model stores register
//   contents and ownership as plain arrays and applies the architectural
//   rules in order: primary write, then $rstatus write, then busy
//   release/claim.
// ----------------------------------------------------------------------------
module tb_regfile_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NREAD = 3;
  localparam int AW    = 5;
  localparam int SIDX  = DEPTH - 1;

  logic                   clock;
  logic                   ctrl_reset;
  logic                   ctrl_writeEnable;
  logic [AW-1:0]          ctrl_writeReg;
  logic [WIDTH-1:0]       data_writeReg;
  logic                   rs_write;
  logic [WIDTH-1:0]       rs_writeData;
  logic [NREAD*AW-1:0]    ctrl_readReg;
  logic [NREAD*WIDTH-1:0] data_readReg;
  logic                   sb_set;
  logic [AW-1:0]          sb_setReg;
  logic [NREAD-1:0]       sb_busy;
  logic [AW:0]            sb_count;
  logic                   sb_full;

  regfile_param #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NREAD (NREAD)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .rs_write         (rs_write),
    .rs_writeData     (rs_writeData),
    .ctrl_readReg     (ctrl_readReg),
    .data_readReg     (data_readReg),
    .sb_set           (sb_set),
    .sb_setReg        (sb_setReg),
    .sb_busy          (sb_busy),
    .sb_count         (sb_count),
    .sb_full          (sb_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [NREAD*WIDTH-1:0] rd;
    logic [NREAD-1:0]       busy;
    logic [AW:0]            cnt;
    logic                   full;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] m_mem  [DEPTH];
  bit               m_busy [DEPTH];
  logic [AW-1:0]    rd_a   [NREAD];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the stimulus side predicted for this cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int k = 0; k < NREAD; k++) begin
        check($sformatf("rd%0d", k), 64'(data_readReg[k*WIDTH +: WIDTH]),
              64'(e.rd[k*WIDTH +: WIDTH]));
      end
      check("sb_busy",  64'(sb_busy),  64'(e.busy));
      check("sb_count", 64'(sb_count), 64'(e.cnt));
      check("sb_full",  64'(sb_full),  64'(e.full));
    end
  end

  // One clock of stimulus. Expected outputs come from the model state before
  // the edge; the model then applies this cycle's writes at the edge.
  task automatic step(input bit push, input bit rst,
                      input bit we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                      input bit rs, input logic [WIDTH-1:0] rsd,
                      input bit st, input logic [AW-1:0] sr);
    exp_t e;
    int   c;
    ctrl_reset       = rst;
    ctrl_writeEnable = we;
    ctrl_writeReg    = wa;
    data_writeReg    = wd;
    rs_write         = rs;
    rs_writeData     = rsd;
    sb_set           = st;
    sb_setReg        = sr;
    for (int k = 0; k < NREAD; k++) ctrl_readReg[k*AW +: AW] = rd_a[k];

    for (int k = 0; k < NREAD; k++) begin
      int               a;
      logic [WIDTH-1:0] v;
      bit               b;
      a = int'(rd_a[k]);
      v = m_mem[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (we && a == int'(wa)) begin
        v = wd;
        b = st && (int'(sr) == a);
      end
      if (rs && a == SIDX) begin
        v = rsd;
        b = st && (int'(sr) == a);
      end
`endif
      if (a == 0) begin
        v = '0;
        b = 1'b0;
      end
      e.rd[k*WIDTH +: WIDTH] = v;
      e.busy[k]              = b;
    end
    c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    e.cnt  = (AW+1)'(c);
    e.full = (c == DEPTH - 1);
    if (push) exp_q.push_back(e);

    @(posedge clock);
    if (rst) begin
      foreach (m_mem[i]) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && wa != 0) m_mem[wa] = wd;
      if (rs)            m_mem[SIDX] = rsd;
      if (we)            m_busy[wa] = 1'b0;
      if (rs)            m_busy[SIDX] = 1'b0;
      if (st && sr != 0) m_busy[sr] = 1'b1;
      m_busy[0] = 1'b0;
    end
    #1;
  endtask

  task automatic set_reads(input int a0, input int a1, input int a2);
    rd_a[0] = AW'(a0);
    rd_a[1] = AW'(a1);
    rd_a[2] = AW'(a2);
  endtask

  task automatic idle();
    step(1, 0, 0, '0, '0, 0, '0, 0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    foreach (m_mem[i]) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    set_reads(0, 0, 0);
    @(posedge clock);
    #1;
    // Power-up contents are unknown until the first reset.
    step(0, 1, 0, '0, '0, 0, '0, 0, '0);

    // Reset clears a previously written register and the scoreboard.
    set_reads(5, 5, 0);
    step(1, 0, 1, 5'd5, 32'hDEAD_BEEF, 0, '0, 1, 5'd6);
    step(1, 1, 1, 5'd6, 32'h1, 0, '0, 1, 5'd7);
    idle();

    // r0 ignores writes; r7 visible on every port.
    set_reads(0, 7, 7);
    step(1, 0, 1, 5'd0, 32'h0000_1234, 0, '0, 0, '0);
    step(1, 0, 1, 5'd7, 32'hA5A5_A5A5, 0, '0, 0, '0);
    idle();
    set_reads(7, 7, 7);
    idle();

    // Side write beats a same-cycle primary write to $rstatus.
    set_reads(31, 0, 7);
    step(1, 0, 1, 5'd31, 32'h0000_1111, 1, 32'h0000_2222, 0, '0);
    idle();

    // Scoreboard set, release, and set-wins-over-release.
    set_reads(3, 0, 31);
    step(1, 0, 0, '0, '0, 0, '0, 1, 5'd3);
    idle();
    step(1, 0, 1, 5'd3, 32'h9, 0, '0, 0, '0);
    idle();
    step(1, 0, 0, '0, '0, 0, '0, 1, 5'd3);
    step(1, 0, 1, 5'd3, 32'hA, 0, '0, 1, 5'd3);
    idle();

    // Fill the scoreboard, then a redundant claim must not move the count.
    set_reads(1, 4, 31);
    for (int r = 1; r < DEPTH; r++) begin
      step(1, 0, 0, '0, '0, 0, '0, 1, AW'(r));
    end
    idle();
    step(1, 0, 0, '0, '0, 0, '0, 1, 5'd4);
    idle();
    // Release r31 via side write and r4 via primary write in one cycle.
    step(1, 0, 1, 5'd4, 32'h44, 1, 32'h55, 0, '0);
    idle();
    step(1, 1, 0, '0, '0, 0, '0, 0, '0);

    // Same-cycle write and read of r9.
    set_reads(9, 9, 0);
    step(1, 0, 1, 5'd9, 32'h0000_0077, 0, '0, 0, '0);
    idle();

    // Randomised traffic; writes are steered onto read addresses often.
    for (int n = 0; n < 500; n++) begin
      logic [AW-1:0] wa;
      for (int k = 0; k < NREAD; k++) rd_a[k] = AW'($urandom_range(0, DEPTH - 1));
      wa = ($urandom_range(0, 2) == 0) ? rd_a[0] : AW'($urandom_range(0, DEPTH - 1));
      step(1, ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 1) == 1), wa, $urandom(),
           ($urandom_range(0, 4) == 0), $urandom(),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1)));
    end

    repeat (3) @(negedge clock);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
